// File: rtl/timer_sched_pkg.sv
// ---------------------------------------------------------------------------
// timer_sched_pkg
// Shared constants and types for the timer channel scheduler:
//   register offsets on the I/O bus, the scan-state enum and STATUS bit
//   positions.
// ---------------------------------------------------------------------------
package timer_sched_pkg;

    localparam logic [3:0] ADDR_CTRL        = 4'h0;
    localparam logic [3:0] ADDR_STATUS      = 4'h1;
    localparam logic [3:0] ADDR_RELOAD_BASE = 4'h4;
    localparam logic [3:0] ADDR_COUNT_BASE  = 4'h8;

    localparam int OVERRUN_BIT  = 31;
    localparam int PERIODIC_LSB = 8;

    typedef enum logic {
        SCH_IDLE = 1'b0,
        SCH_SCAN = 1'b1
    } sch_state_e;

endpackage

// File: rtl/tsch_prio_arbiter.sv
// ---------------------------------------------------------------------------
// tsch_prio_arbiter
// Fixed-priority (lowest index wins) arbiter over the pending vector.
// Purely combinational.
//   pending_i  in   NUM_CH     pending interrupt bits
//   valid_o    out  1          any bit pending
//   idx_o      out  IDX_W      lowest pending index (0 when none)
// ---------------------------------------------------------------------------
module tsch_prio_arbiter #(
    parameter int  NUM_CH = 4,
    localparam int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pending_i,
    output logic              valid_o,
    output logic [IDX_W-1:0]  idx_o
);

    always_comb begin
        valid_o = |pending_i;
        idx_o   = '0;
        // Walk from the top down so the lowest set index is the last writer.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/timer_channel_scheduler.sv
// ---------------------------------------------------------------------------
// timer_channel_scheduler
// Shares the system-timer tick among NUM_CH timer channels using a single
// decrementer that visits one channel per cycle after each tick. Expiries
// raise pending bits which are presented to the CPU with a req/ack handshake.
//   Clock        in   1         clock
//   Reset        in   1         async active-high reset
//   BlockSelect  in   1         block addressed on the I/O bus
//   RegAddress   in   4         register offset
//   WrEn         in   1         write strobe (qualified by BlockSelect)
//   WrData       in   32        write data
//   RdData       out  32        combinational read data (0 if not selected)
//   TickIn       in   1         one-cycle tick from the system timer
//   IntReq       out  1         registered interrupt request
//   IntId        out  IDX_W     channel of IntReq, frozen while IntReq=1
//   IntAck       in   1         one-cycle acknowledge
//
// state    | meaning
// SCH_IDLE | waiting for a tick (or a tick latched during the last scan)
// SCH_SCAN | visiting channel idx_q this cycle, one channel per cycle
// ---------------------------------------------------------------------------
module timer_channel_scheduler
    import timer_sched_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  CNT_W  = 32,
    localparam int IDX_W  = $clog2(NUM_CH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             BlockSelect,
    input  logic [3:0]       RegAddress,
    input  logic             WrEn,
    input  logic [31:0]      WrData,
    output logic [31:0]      RdData,
    input  logic             TickIn,
    output logic             IntReq,
    output logic [IDX_W-1:0] IntId,
    input  logic             IntAck
);

    logic [NUM_CH-1:0] enable_q,   enable_d;
    logic [NUM_CH-1:0] periodic_q, periodic_d;
    logic [NUM_CH-1:0] pending_q,  pending_d;
    logic [CNT_W-1:0]  reload_q [NUM_CH];
    logic [CNT_W-1:0]  reload_d [NUM_CH];
    logic [CNT_W-1:0]  count_q  [NUM_CH];
    logic [CNT_W-1:0]  count_d  [NUM_CH];

    sch_state_e        state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              tick_pend_q;
    logic              overrun_q;
    logic              int_req_q;
    logic [IDX_W-1:0]  int_id_q;

    logic              wr;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  cur_cnt;
    logic              arb_valid;
    logic [IDX_W-1:0]  arb_idx;

    assign wr      = BlockSelect && WrEn;
    assign wr_cnt  = WrData[CNT_W-1:0];
    assign cur_cnt = count_q[idx_q];

    // Register file writes and the shared decrementer.
    always_comb begin
        enable_d   = enable_q;
        periodic_d = periodic_q;
        pending_d  = pending_q;
        reload_d   = reload_q;
        count_d    = count_q;

        if (wr && RegAddress == ADDR_CTRL) begin
            enable_d   = WrData[NUM_CH-1:0];
            periodic_d = WrData[PERIODIC_LSB +: NUM_CH];
            for (int k = 0; k < NUM_CH; k++) begin
                if (!enable_q[k] && WrData[k]) begin
                    count_d[k] = reload_q[k];
                end
            end
        end

        for (int k = 0; k < NUM_CH; k++) begin
            if (wr && RegAddress == ADDR_RELOAD_BASE + 4'(k) &&
                !enable_q[k] && wr_cnt != '0) begin
                reload_d[k] = wr_cnt;
            end
        end

        if (wr && RegAddress == ADDR_STATUS) begin
            pending_d = pending_d & ~WrData[NUM_CH-1:0];
        end
        if (int_req_q && IntAck) begin
            pending_d[int_id_q] = 1'b0;
        end

        // Expiry comes last so a set beats any clear on the same bit.
        if (state_q == SCH_SCAN && enable_q[idx_q]) begin
            if (cur_cnt > CNT_W'(1)) begin
                count_d[idx_q] = cur_cnt - CNT_W'(1);
            end else if (cur_cnt == CNT_W'(1)) begin
                pending_d[idx_q] = 1'b1;
                if (periodic_q[idx_q]) begin
                    count_d[idx_q] = reload_q[idx_q];
                end else begin
                    count_d[idx_q]  = '0;
                    enable_d[idx_q] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            enable_q   <= '0;
            periodic_q <= '0;
            pending_q  <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                reload_q[k] <= CNT_W'(1);
                count_q[k]  <= '0;
            end
        end else begin
            enable_q   <= enable_d;
            periodic_q <= periodic_d;
            pending_q  <= pending_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
        end
    end

    // Scan FSM, one-deep tick latch and sticky overrun flag.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= SCH_IDLE;
            idx_q       <= '0;
            tick_pend_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (wr && RegAddress == ADDR_STATUS && WrData[OVERRUN_BIT]) begin
                overrun_q <= 1'b0;
            end
            case (state_q)
                SCH_IDLE: begin
                    if (tick_pend_q || TickIn) begin
                        state_q     <= SCH_SCAN;
                        idx_q       <= '0;
                        // A fresh tick arriving while the latched one is consumed stays latched.
                        tick_pend_q <= tick_pend_q && TickIn;
                    end
                end
                SCH_SCAN: begin
                    if (TickIn) begin
                        if (tick_pend_q) begin
                            overrun_q <= 1'b1;
                        end else begin
                            tick_pend_q <= 1'b1;
                        end
                    end
                    if (idx_q == IDX_W'(NUM_CH - 1)) begin
                        state_q <= SCH_IDLE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: state_q <= SCH_IDLE;
            endcase
        end
    end

    tsch_prio_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .pending_i (pending_q),
        .valid_o   (arb_valid),
        .idx_o     (arb_idx)
    );

    // Request drops on ack, or when its pending bit was cleared by W1C.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            int_req_q <= 1'b0;
            int_id_q  <= '0;
        end else if (!int_req_q) begin
            if (arb_valid) begin
                int_req_q <= 1'b1;
                int_id_q  <= arb_idx;
            end
        end else if (IntAck || !pending_q[int_id_q]) begin
            int_req_q <= 1'b0;
        end
    end

    assign IntReq = int_req_q;
    assign IntId  = int_id_q;

    always_comb begin
        RdData = '0;
        if (BlockSelect) begin
            if (RegAddress == ADDR_CTRL) begin
                RdData[NUM_CH-1:0]              = enable_q;
                RdData[PERIODIC_LSB +: NUM_CH]  = periodic_q;
            end
            if (RegAddress == ADDR_STATUS) begin
                RdData[NUM_CH-1:0]  = pending_q;
                RdData[OVERRUN_BIT] = overrun_q;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (RegAddress == ADDR_RELOAD_BASE + 4'(k)) begin
                    RdData = 32'(reload_q[k]);
                end
                if (RegAddress == ADDR_COUNT_BASE + 4'(k)) begin
                    RdData = 32'(count_q[k]);
                end
            end
        end
    end

endmodule
